// File: rtl/regular_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : regular_ctrl_if
//  Purpose  : Bundles the upstream pixel handshake, the regular-coder core
//             drive and the frame status signals of regular_ctrl.
//  Ports    : (interface signals)
//             i_start, i_vl, i_last, i_x[7:0], i_px[7:0], i_s, i_qh[4:0]
//                                      - upstream frame/pixel stream
//             o_rdy                    - upstream ready
//             c_rstn, c_vl, c_x[7:0], c_px[7:0], c_s, c_qh[4:0]
//                                      - core context-init and pixel drive
//             o_busy, o_done           - frame status
//             o_pixcnt[23:0]           - only with REGULAR_CTRL_PIXCNT_EN
//  Modports : master (upstream / environment side), slave (regular_ctrl)
//  Config   : REGULAR_CTRL_PIXCNT_EN adds o_pixcnt
//  Revision : 1.0 - initial release
// ============================================================================
interface regular_ctrl_if;
  logic        i_start;
  logic        i_vl;
  logic        i_last;
  logic [7:0]  i_x;
  logic [7:0]  i_px;
  logic        i_s;
  logic [4:0]  i_qh;
  logic        o_rdy;
  logic        c_rstn;
  logic        c_vl;
  logic [7:0]  c_x;
  logic [7:0]  c_px;
  logic        c_s;
  logic [4:0]  c_qh;
  logic        o_busy;
  logic        o_done;
`ifdef REGULAR_CTRL_PIXCNT_EN
  logic [23:0] o_pixcnt;
`endif

  modport master (
`ifdef REGULAR_CTRL_PIXCNT_EN
    input  o_pixcnt,
`endif
    output i_start, i_vl, i_last, i_x, i_px, i_s, i_qh,
    input  o_rdy, c_rstn, c_vl, c_x, c_px, c_s, c_qh, o_busy, o_done
  );

  modport slave (
`ifdef REGULAR_CTRL_PIXCNT_EN
    output o_pixcnt,
`endif
    input  i_start, i_vl, i_last, i_x, i_px, i_s, i_qh,
    output o_rdy, c_rstn, c_vl, c_x, c_px, c_s, c_qh, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/regular_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regular_ctrl
//  Purpose  : Frame sequencer for the JPEG-LS regular-mode coder. Holds the
//             core in context-init for INIT_LEN cycles per frame, gates the
//             pixel stream into the core, then waits DRAIN_LEN cycles after
//             the last pixel before pulsing o_done.
//  Params   : INIT_LEN  (28..63) cycles c_rstn is held low per frame
//             DRAIN_LEN (1..63)  cycles from last core input to o_done
//  Ports    : clk    - clock, rising edge
//             rst    - asynchronous active-high reset
//             bus    - regular_ctrl_if.slave (handshake, core drive, status)
//  Config   : REGULAR_CTRL_PIXCNT_EN enables the saturating 24-bit per-frame
//             accepted-pixel counter on bus.o_pixcnt
//  Revision : 1.0 - initial release
// ============================================================================
module regular_ctrl #(
  parameter int INIT_LEN  = 36,
  parameter int DRAIN_LEN = 12
) (
  input  wire logic     clk,
  input  wire logic     rst,
  regular_ctrl_if.slave bus
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_INIT  = 2'd1;
  localparam logic [1:0] C_RUN   = 2'd2;
  localparam logic [1:0] C_DRAIN = 2'd3;

  localparam logic [5:0] C_INIT_LOAD  = 6'(INIT_LEN - 1);
  localparam logic [5:0] C_DRAIN_LOAD = 6'(DRAIN_LEN - 1);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [5:0] r_cnt;
  logic       w_cnt_zero;
  logic       w_accept;
  logic       w_start;

  assign w_cnt_zero = (r_cnt == 6'd0);
  assign w_accept   = bus.i_vl & bus.o_rdy;
  // A start is only honoured from IDLE; anywhere else it is dropped.
  assign w_start    = bus.i_start & (r_state == C_IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE:  if (bus.i_start)               w_next_state = C_INIT;
      C_INIT:  if (w_cnt_zero)                w_next_state = C_RUN;
      C_RUN:   if (w_accept && bus.i_last)    w_next_state = C_DRAIN;
      C_DRAIN: if (w_cnt_zero)                w_next_state = C_IDLE;
      default:                                w_next_state = C_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.o_rdy  = (r_state == C_RUN);
    bus.o_busy = (r_state != C_IDLE);
  end

  // --------------------------------------------------------------------------
  // Shared INIT/DRAIN down-counter. It parks at 0 in IDLE and RUN; the
  // transition into INIT or DRAIN always reloads it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 6'd0;
    end else begin
      case (r_state)
        C_IDLE:  if (bus.i_start)            r_cnt <= C_INIT_LOAD;
        C_RUN:   if (w_accept && bus.i_last) r_cnt <= C_DRAIN_LOAD;
        default: if (!w_cnt_zero)            r_cnt <= r_cnt - 6'd1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered core control and frame-complete pulse. c_rstn follows the
  // next state so it is low for exactly the cycles spent in INIT, and reset
  // leaves it low so the core also sweeps its contexts during rst.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.c_rstn <= 1'b0;
      bus.o_done <= 1'b0;
    end else begin
      bus.c_rstn <= (w_next_state != C_INIT);
      bus.o_done <= (r_state == C_DRAIN) && w_cnt_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Core pixel register: data only updates on accept, so it holds while
  // c_vl is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.c_vl <= 1'b0;
      bus.c_x  <= 8'd0;
      bus.c_px <= 8'd0;
      bus.c_s  <= 1'b0;
      bus.c_qh <= 5'd0;
    end else begin
      bus.c_vl <= w_accept;
      if (w_accept) begin
        bus.c_x  <= bus.i_x;
        bus.c_px <= bus.i_px;
        bus.c_s  <= bus.i_s;
        bus.c_qh <= bus.i_qh;
      end
    end
  end

`ifdef REGULAR_CTRL_PIXCNT_EN
  // --------------------------------------------------------------------------
  // Per-frame accepted-pixel count; cleared at an honoured start, saturating,
  // and held through DRAIN/IDLE so it can be read after o_done.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_pixcnt <= 24'd0;
    end else if (w_start) begin
      bus.o_pixcnt <= 24'd0;
    end else if (w_accept && (bus.o_pixcnt != 24'hFFFFFF)) begin
      bus.o_pixcnt <= bus.o_pixcnt + 24'd1;
    end
  end
`else
  // Without the pixel counter the honoured-start decode has no consumer.
  logic w_start_unused;
  assign w_start_unused = w_start;
`endif

endmodule
`default_nettype wire

// File: doc/regular_ctrl.md
# regular_ctrl

Frame sequencer for the JPEG-LS regular-mode coding pipeline. It sits between the context/prediction front end and the 11-stage regular coder core. It holds the core in its context-initialisation state long enough for all 28 context entries (N, A, B, C) to be rewritten at every frame start. It then gates the pixel stream into the core with a ready/valid handshake and reports frame completion once the pipeline has drained.

## Interface
Parameters:
- INIT_LEN, 36: cycles the core's context-init reset is held low per frame. Legal range 28..63. 36 covers the 28-entry sweep plus the write-back stage offset.
- DRAIN_LEN, 12: cycles from the last core input to `o_done`. Legal range 1..63. 12 equals the core's input-to-output latency plus one.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- i_start, in, 1: frame-start pulse; honoured only in IDLE.
- i_vl, in, 1: upstream pixel valid.
- i_last, in, 1: qualifies the accepted pixel as the frame's last.
- i_x, in, 8: pixel value.
- i_px, in, 8: prediction.
- i_s, in, 1: context sign.
- i_qh, in, 5: context index, 0..27.
- o_rdy, out, 1: upstream ready; a pixel is accepted when `i_vl & o_rdy`.
- c_rstn, out, 1: core context-init control, active-low.
- c_vl, out, 1: core valid.
- c_x, out, 8: core pixel.
- c_px, out, 8: core prediction.
- c_s, out, 1: core sign.
- c_qh, out, 5: core context index.
- o_busy, out, 1: high whenever the state is not IDLE.
- o_done, out, 1: one-cycle frame-complete pulse.
- o_pixcnt, out, 24: present only with REGULAR_CTRL_PIXCNT_EN.

## Operation
- State machine: IDLE, INIT, RUN, DRAIN. There is one 6-bit down-counter, shared by INIT and DRAIN.
- IDLE:
  - `i_start` loads the counter with INIT_LEN-1 and moves to INIT.
  - `i_vl` is ignored because `o_rdy` is 0.
- INIT:
  - `c_rstn` is 0; the core sweeps its context index internally.
  - The counter decrements each cycle. At 0, move to RUN.
- RUN:
  - `o_rdy` is 1.
  - On accept, register `i_x`/`i_px`/`i_s`/`i_qh` into `c_*` and set `c_vl` = 1 next cycle. Otherwise `c_vl` = 0 next cycle.
  - An accept with `i_last` = 1 loads the counter with DRAIN_LEN-1 and moves to DRAIN.
- DRAIN:
  - The counter decrements each cycle. At 0, move to IDLE and pulse `o_done` for 1 cycle.
- `i_start` outside IDLE is ignored, including the cycle of the RUN→DRAIN transition.
- `i_last` without `i_vl`, or while `o_rdy` = 0, has no effect.
- `c_x`/`c_px`/`c_s`/`c_qh` hold their last value when `c_vl` = 0.
- `o_rdy` and `o_busy` are decoded directly from the state register. `c_*`, `c_rstn` and `o_done` are flops.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - `c_rstn` = 0, so the core sweeps contexts while `rst` is asserted.
  - `c_vl` = 0; `c_x`/`c_px`/`c_s`/`c_qh` = 0.
  - `o_rdy` = 0, `o_busy` = 0, `o_done` = 0, `o_pixcnt` = 0.
- `c_rstn` returns to 1 on the first clock after `rst` deasserts.
- `i_start` at cycle T:
  - INIT and `c_rstn` = 0 span cycles T+1..T+INIT_LEN.
  - `o_rdy` = 1 from T+INIT_LEN+1.
- Accept at cycle P gives `c_vl` = 1 at P+1. Core output follows at P+12.
- Last accept at L:
  - DRAIN spans L+1..L+DRAIN_LEN.
  - `o_done` = 1 and the state is IDLE at L+DRAIN_LEN+1.
  - `i_start` in that cycle is honoured.
- Back-to-back accepts are allowed every cycle in RUN. There is no bubble insertion.
- `rst` mid-frame aborts immediately to reset values. Any partially coded frame is discarded, with no `o_done`.

## Configuration
- REGULAR_CTRL_PIXCNT_EN defined:
  - `o_pixcnt` port exists.
  - It clears on the cycle `i_start` is honoured and increments on every accept.
  - It saturates at 24'hFFFFFF and holds its value through DRAIN and IDLE until the next start.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then start: `rst` 1→0, `i_start` at T=5 → `c_rstn` = 0 on cycles 6..41, `o_rdy` = 1 at 42, `o_busy` = 1 from 6.
- Streaming: 4 pixels accepted back-to-back at 42..45 with `i_qh` = 3,3,7,27 → `c_vl` = 1 at 43..46 with matching `c_qh`. The last has `i_last` = 1 → `o_rdy` = 0 at 46, `o_done` = 1 exactly at 58.
- Stalls: `i_vl` toggling 1,0,1 in RUN → `c_vl` = 1,0,1 one cycle later. `c_x` holds during the gap.
- Ignored inputs:
  - `i_vl` = 1 in IDLE and INIT → no `c_vl`.
  - `i_start` during RUN and DRAIN → no re-init.
  - `i_start` in the `o_done` cycle → INIT begins next cycle.
- Abort: `rst` asserted at cycle 3 of DRAIN → all outputs reach reset values asynchronously and `o_done` never pulses.
- PIXCNT_EN: 5 pixels in frame 1, then 2 pixels in frame 2 → `o_pixcnt` reads 5 after frame 1, clears at the second start, and reads 2 after frame 2.
